pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; rst=0 forces the reset state immediately, independent of clk.
REQ-003 id_op  input  6  opcode in ID stage; 6'b111111 = NONE (bubble).
REQ-004 id_rs, id_rt  input  5 each  source register fields in ID.
REQ-005 ex_memread  input  1  load instruction in EX.
REQ-006 ex_rt  input  5  destination register of the load in EX.
REQ-007 branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-008 mem_busy  input  1  data memory not ready this cycle.
REQ-009 run  output  1  global pipeline advance; drives run of the control unit and datapath; 0 freezes all stages.
REQ-010 hold_front  output  1  freeze PC and the IF/ID register only.
REQ-011 bubble  output  1  load NONE into ID/EX instead of the ID opcode.
REQ-012 flush  output  1  replace IF/ID and ID/EX contents with NONE at the next edge.
REQ-013 mem_timeout  output  1  sticky error: memory wait exceeded its limit.
REQ-014 stall_count  output  16  saturating count of stall cycles.

Function
REQ-015 FSM states: INIT, RUN, WAIT, ERR; state, init_cnt (2b), wait_cnt (8b) and stall_count are the only registers, and all outputs except stall_count are combinational from state and inputs.
REQ-016 INIT: run=0, flush=1, hold_front=0, bubble=0; init_cnt increments each cycle; INIT->RUN at the edge where init_cnt==3, giving exactly 4 INIT cycles after rst deasserts.
REQ-017 uses_rt = (id_op==6'b000000) | (id_op[5:3]==3'b101) | (id_op[5:1]==5'b00010).
REQ-018 load_use = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (uses_rt & ex_rt==id_rt)) & (id_op!=6'b111111).
REQ-019 RUN priority, highest first, evaluated per cycle:
REQ-020 (a) mem_busy=1: run=0, flush=0, hold_front=0, bubble=0; RUN->WAIT at the edge.
REQ-021 (b) branch_taken=1: run=1, flush=1, hold_front=0, bubble=0; load_use ignored; stay RUN.
REQ-022 (c) load_use=1: run=1, hold_front=1, bubble=1, flush=0; stay RUN; with the 1-cycle load latency exactly one bubble is inserted per load-use pair.
REQ-023 (d) otherwise: run=1, others 0.
REQ-024 wait_cnt is cleared every cycle in RUN.
REQ-025 WAIT with mem_busy=1: run=0, other outputs 0, wait_cnt increments; branch_taken and load_use are masked.
REQ-026 WAIT with mem_busy=0: outputs as RUN rules (b)-(d) for this cycle; WAIT->RUN at the edge.
REQ-027 WAIT->ERR at the edge where mem_busy=1 and wait_cnt==8'hFF, i.e. after 257 consecutive busy cycles counting the RUN cycle.
REQ-028 ERR: run=0, flush=0, hold_front=0, bubble=0, mem_timeout=1; ERR is exited only by reset.
REQ-029 mem_timeout=0 in all states other than ERR.
REQ-030 stall_count increments at each edge where (run==0 | hold_front==1) and state!=INIT; it saturates at 16'hFFFF and does not wrap.

Reset
REQ-031 While rst=0: state=INIT, init_cnt=0, wait_cnt=0, stall_count=0; outputs run=0, flush=1, hold_front=0, bubble=0, mem_timeout=0.
REQ-032 rst assertion mid-WAIT or in ERR returns the block to INIT immediately, without waiting for clk; ERR, mem_timeout and stall_count are cleared.

Verification
REQ-033 Release rst, all inputs 0 -> run=0 and flush=1 for 4 cycles, then run=1 and flush=0; stall_count=0.
REQ-034 id_op=6'b000000, id_rs=5, ex_memread=1, ex_rt=5 for 1 cycle -> hold_front=1 and bubble=1 that cycle only; stall_count=1. Repeat with ex_rt=0 -> no stall.
REQ-035 load_use and branch_taken in the same cycle -> flush=1, bubble=0, hold_front=0; stall_count unchanged.
REQ-036 mem_busy=1 for 10 cycles with branch_taken=1 -> run=0 for 10 cycles, flush=0 throughout; the first non-busy cycle gives flush=1; stall_count=10.
REQ-037 mem_busy held for 300 cycles -> mem_timeout=1 after edge 257, stays 1 with mem_busy then dropped; rst pulse low -> mem_timeout=0 and stall_count=0 immediately.
REQ-038 Force stall_count to 16'hFFFE via a long stall -> it reaches 16'hFFFF and holds.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Pipeline hazard controller. Sequences start-up flushing,
//                load-use bubbles, branch flushes, memory-wait freezes with a
//                timeout trap, and a saturating stall-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  id_op,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        run,
    output logic        hold_front,
    output logic        bubble,
    output logic        flush,
    output logic        mem_timeout,
    output logic [15:0] stall_count
);

    localparam logic [5:0]  C_OP_NONE   = 6'b111111;
    localparam logic [7:0]  C_WAIT_LAST = 8'hFF;
    localparam logic [15:0] C_STALL_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  init_cnt_q, init_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic        w_uses_rt;
    logic        w_load_use;
    logic        w_advance;
    logic        w_stall_inc;

    assign w_uses_rt  = (id_op == 6'b000000) | (id_op[5:3] == 3'b101) | (id_op[5:1] == 5'b00010);
    assign w_load_use = ex_memread & (ex_rt != 5'd0)
                      & ((ex_rt == id_rs) | (w_uses_rt & (ex_rt == id_rt)))
                      & (id_op != C_OP_NONE);

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        w_advance   = 1'b0;
        run         = 1'b0;
        hold_front  = 1'b0;
        bubble      = 1'b0;
        flush       = 1'b0;
        mem_timeout = 1'b0;

        case (state_q)
            ST_INIT: begin
                flush      = 1'b1;
                init_cnt_d = init_cnt_q + 2'd1;
                if (init_cnt_q == 2'd3) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                wait_cnt_d = 8'd0;
                if (mem_busy) begin
                    state_d = ST_WAIT;
                end else begin
                    w_advance = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_busy) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_q == C_WAIT_LAST) begin
                        state_d = ST_ERR;
                    end
                end else begin
                    w_advance  = 1'b1;
                    wait_cnt_d = 8'd0;
                    state_d    = ST_RUN;
                end
            end
            ST_ERR: begin
                mem_timeout = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // A taken branch squashes the dependent instruction, so no bubble is needed.
        if (w_advance) begin
            run = 1'b1;
            if (branch_taken) begin
                flush = 1'b1;
            end else if (w_load_use) begin
                hold_front = 1'b1;
                bubble     = 1'b1;
            end
        end
    end

    assign w_stall_inc   = (state_q != ST_INIT) & (~run | hold_front) & (stall_count_q != C_STALL_MAX);
    assign stall_count_d = w_stall_inc ? (stall_count_q + 16'd1) : stall_count_q;
    assign stall_count   = stall_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= 2'd0;
            wait_cnt_q    <= 8'd0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

`default_nettype wire
